replica_exchange_sched: RTL and testbench

- Sequences one or more replica-exchange rounds for the replica array: asserts the per-round clear, primes and runs the exp units, fires the exchange decision, then streams the ordering read/write shift.
- Alternates the pairing parity (OR0/OR1) every round.
- Sits between the top-level run control and all replica instances; its outputs broadcast to every replica.

---
 rtl/replica_exchange_sched.sv | 186 ++++++++++++++++++
 tb/tb_replica_exchange_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/replica_exchange_sched.sv
// ============================================================================
// Module   : replica_exchange_sched
// Brief    : Sequences replica-exchange rounds: clear, exp prime/run, exchange
//            decision and ordering shift, alternating OR0/OR1 pairing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package replica_exchange_pkg;
    typedef enum logic {
        OR0 = 1'b0,
        OR1 = 1'b1
    } opt_command_t;
endpackage

module replica_exchange_sched
    import replica_exchange_pkg::*;
#(
    parameter int REPLICA_NUM = 32,
    parameter int EXP_CYCLES  = 12,
    parameter int ROUND_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [ROUND_W-1:0] num_rounds,
    input  logic [16:0]        recip_in,
    output logic               replica_run,
    output opt_command_t       opt_command,
    output logic               exp_init,
    output logic               exp_run,
    output logic [16:0]        exp_recip,
    output logic               exchange_run,
    output logic               exchange_shift_d,
    output logic               busy,
    output logic               done,
    output logic [ROUND_W-1:0] round_cnt
);

    localparam int c_EXP_W   = (EXP_CYCLES  > 1) ? $clog2(EXP_CYCLES)  : 1;
    localparam int c_SHIFT_W = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1;

    localparam logic [c_EXP_W-1:0]   c_EXP_LOAD  = c_EXP_W'(EXP_CYCLES - 1);
    localparam logic [c_SHIFT_W-1:0] c_SHIFT_LAST = c_SHIFT_W'(REPLICA_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_INIT  = 3'd2,
        S_EXP   = 3'd3,
        S_TEST  = 3'd4,
        S_EXCH  = 3'd5,
        S_SHIFT = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_EXP_W-1:0]   r_exp_cnt;
    logic [c_SHIFT_W-1:0] r_shift_cnt;
    logic [ROUND_W-1:0]   r_round_cnt;
    opt_command_t         r_opt;
    logic [16:0]          r_exp_recip;

    logic                 w_last_shift;
    logic                 w_exp_last;
    logic [ROUND_W:0]     w_rounds_next;
    logic [ROUND_W:0]     w_target;
    logic                 w_finish;

    assign w_last_shift  = (r_state == S_SHIFT) && (r_shift_cnt == c_SHIFT_LAST);
    assign w_exp_last    = (r_exp_cnt == '0);
    // Widened by one bit so an all-ones round count still compares correctly
    assign w_rounds_next = {1'b0, r_round_cnt} + {{ROUND_W{1'b0}}, 1'b1};
    assign w_target      = (num_rounds == '0) ? {{ROUND_W{1'b0}}, 1'b1}
                                              : {1'b0, num_rounds};
    assign w_finish      = (w_rounds_next >= w_target) || stop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_exp_cnt   <= '0;
            r_shift_cnt <= '0;
            r_round_cnt <= '0;
            r_opt       <= OR0;
            r_exp_recip <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_round_cnt <= '0;
                    end
                end
                S_CLR: begin
                    r_exp_recip <= recip_in;
                end
                S_INIT: begin
                    r_exp_cnt <= c_EXP_LOAD;
                end
                S_EXP: begin
                    if (!w_exp_last) begin
                        r_exp_cnt <= r_exp_cnt - 1'b1;
                    end
                end
                S_EXCH: begin
                    r_shift_cnt <= '0;
                end
                S_SHIFT: begin
                    r_shift_cnt <= r_shift_cnt + 1'b1;
                    if (w_last_shift) begin
                        r_shift_cnt <= '0;
                        if (!(&r_round_cnt)) begin
                            r_round_cnt <= r_round_cnt + 1'b1;
                        end
                        r_opt <= (r_opt == OR0) ? OR1 : OR0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state     = r_state;
        replica_run      = 1'b0;
        exp_init         = 1'b0;
        exp_run          = 1'b0;
        exchange_run     = 1'b0;
        exchange_shift_d = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_CLR;
                end
            end
            S_CLR: begin
                replica_run  = 1'b1;
                w_next_state = S_INIT;
            end
            S_INIT: begin
                exp_init     = 1'b1;
                w_next_state = S_EXP;
            end
            S_EXP: begin
                exp_run = 1'b1;
                if (w_exp_last) begin
                    w_next_state = S_TEST;
                end
            end
            S_TEST: begin
                w_next_state = S_EXCH;
            end
            S_EXCH: begin
                exchange_run = 1'b1;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                exchange_shift_d = 1'b1;
                if (w_last_shift) begin
                    w_next_state = w_finish ? S_FIN : S_CLR;
                end
            end
            S_FIN: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign opt_command = r_opt;
    assign exp_recip   = r_exp_recip;
    assign round_cnt   = r_round_cnt;

endmodule

`default_nettype wire

// File: tb/tb_replica_exchange_sched.sv
// ============================================================================
// Module   : tb_replica_exchange_sched
// Brief    : Directed bench for replica_exchange_sched with a round-offset
//            reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_replica_exchange_sched;
    import replica_exchange_pkg::*;

    localparam int RN = 32;
    localparam int EC = 12;
    localparam int RW = 16;
    localparam int RL = RN + EC + 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [RW-1:0]  num_rounds = '0;
    logic [16:0]    recip_in = '0;
    logic           replica_run, exp_init, exp_run, exchange_run;
    logic           exchange_shift_d, busy, done;
    opt_command_t   opt_command;
    logic [16:0]    exp_recip;
    logic [RW-1:0]  round_cnt;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    replica_exchange_sched #(
        .REPLICA_NUM (RN),
        .EXP_CYCLES  (EC),
        .ROUND_W     (RW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .num_rounds       (num_rounds),
        .recip_in         (recip_in),
        .replica_run      (replica_run),
        .opt_command      (opt_command),
        .exp_init         (exp_init),
        .exp_run          (exp_run),
        .exp_recip        (exp_recip),
        .exchange_run     (exchange_run),
        .exchange_shift_d (exchange_shift_d),
        .busy             (busy),
        .done             (done),
        .round_cnt        (round_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: position within a batch as (round offset, rounds done)
    bit          m_busy = 0;
    bit          m_fin = 0;
    int          m_off = 0;
    int          m_rc = 0;
    bit          m_opt = 0;
    logic [16:0] m_recip = '0;

    always @(posedge clk) begin
        int tgt;
        if (!reset) begin
            m_busy = 0; m_fin = 0; m_off = 0; m_rc = 0; m_opt = 0; m_recip = '0;
        end else if (m_fin) begin
            m_fin = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_off = 0; m_rc = 0;
            end
        end else begin
            if (m_off == 0) m_recip = recip_in;
            if (m_off == RL - 1) begin
                if (m_rc < (1 << RW) - 1) m_rc++;
                m_opt = ~m_opt;
                tgt = (num_rounds == 0) ? 1 : int'(num_rounds);
                if (m_rc >= tgt || stop) m_fin = 1;
                m_off = 0;
            end else begin
                m_off++;
            end
        end
    end

    function automatic logic [40:0] model_vec();
        bit r;
        r = m_busy && !m_fin;
        return {r && m_off == 0, m_opt, r && m_off == 1,
                r && m_off >= 2 && m_off < 2 + EC, m_recip,
                r && m_off == EC + 3, r && m_off >= EC + 4,
                m_busy, m_fin, RW'(m_rc)};
    endfunction

    always @(negedge clk) begin
        logic [40:0] act, exp_v;
        if (cmp_en) begin
            act = {replica_run, opt_command == OR1, exp_init, exp_run, exp_recip,
                   exchange_run, exchange_shift_d, busy, done, round_cnt};
            exp_v = model_vec();
            total++;
            if (act === exp_v) passed++;
            else $display("FAIL model t=%0t got %h expected %h", $time, act, exp_v);
            total++;
            if ((exchange_run & exchange_shift_d) === 1'b0) passed++;
            else $display("FAIL exch_shift_overlap t=%0t got 1 expected 0", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s got %h expected %h", name, act, exp_v);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) check("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int at;
        logic [3:0] pat;

        do_reset();
        cmp_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_round_cnt", round_cnt, 0);
        check("rst_opt", opt_command, OR0);
        check("rst_exp_recip", exp_recip, 0);

        // Single round, default timing
        num_rounds = 16'd1;
        recip_in = 17'h0ABCD;
        cyc = 0;
        pulse_start();
        check("c1_replica_run", replica_run, 1);
        tick();
        check("c2_exp_init", exp_init, 1);
        check("c2_exp_recip", exp_recip, 17'h0ABCD);
        tick();
        check("c3_exp_run", exp_run, 1);
        run_to(14);
        check("c14_exp_run", exp_run, 1);
        tick();
        check("c15_exp_run_off", exp_run, 0);
        tick();
        check("c16_exchange_run", exchange_run, 1);
        tick();
        check("c17_shift", exchange_shift_d, 1);
        run_to(48);
        check("c48_shift", exchange_shift_d, 1);
        check("c48_opt", opt_command, OR0);
        tick();
        check("c49_done", done, 1);
        check("c49_round_cnt", round_cnt, 1);
        check("c49_busy", busy, 1);
        tick();
        check("c50_busy", busy, 0);
        check("c50_opt", opt_command, OR1);

        // Four rounds back-to-back from reset parity
        do_reset();
        num_rounds = 16'd4;
        recip_in = 17'h1F00F;
        pat = '0;
        cyc = 0;
        pulse_start();
        for (int i = 0; i < 4 * RL; i++) begin
            if (replica_run === 1'b1) pat = {pat[2:0], opt_command == OR1};
            if (done === 1'b1) break;
            tick();
        end
        wait_done(10, at);
        check("r4_done_cycle", at, 4 * RL + 1);
        check("r4_round_cnt", round_cnt, 4);
        check("r4_opt_seq", pat, 4'b0101);

        // Stop during round 2, starts mid-batch and in FIN ignored
        do_reset();
        num_rounds = 16'd10;
        recip_in = 17'h12345;
        cyc = 0;
        pulse_start();
        run_to(29);
        pulse_start();
        run_to(55);
        stop = 1'b1;
        wait_done(200, at);
        check("stop_done_cycle", at, 2 * RL + 1);
        check("stop_round_cnt", round_cnt, 2);
        stop = 1'b0;
        pulse_start();
        check("fin_start_busy", busy, 0);
        tick();
        check("fin_start_replica_run", replica_run, 0);

        // Reset during SHIFT of round 1, then fresh start with num_rounds=0
        do_reset();
        num_rounds = 16'd3;
        cyc = 0;
        pulse_start();
        run_to(20);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_outputs",
              {replica_run, exp_init, exp_run, exchange_run, exchange_shift_d, busy, done},
              0);
        check("midrst_round_cnt", round_cnt, 0);
        num_rounds = 16'd0;
        cyc = 0;
        pulse_start();
        wait_done(100, at);
        check("nr0_done_cycle", at, RL + 1);
        check("nr0_round_cnt", round_cnt, 1);
        tick();
        tick();
        check("nr0_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
